intmul_arbiter: RTL and testbench



---
 rtl/intmul_arbiter.sv | 130 +++++++++++++
 tb/tb_intmul_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/intmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : intmul_arbiter
// Brief    : Round-robin arbiter in front of one shared 12x12 unsigned
//            multiplier. Each accepted operation carries its requester ID
//            through a LAT-deep product pipeline, so every result returns
//            tagged to its originator. A global stall freezes the pipeline
//            without dropping in-flight operations.
// Revision : 1.0 - initial release
// ============================================================================
module intmul_arbiter #(
    parameter  int NREQ = 4,
    parameter  int LAT  = 3,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [12*NREQ-1:0]   req_a,
    input  logic [12*NREQ-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    input  logic                 stall,
    output logic                 rsp_valid,
    output logic [IDW-1:0]       rsp_id,
    output logic [23:0]          rsp_p,
    output logic [15:0]          op_count
);

    // Round-robin pointer and acceptance counter
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [15:0]    cnt_q, cnt_d;

    // Product pipeline; index 0 is stage 1, index LAT-1 is the response stage
    logic [LAT-1:0] vld_q, vld_d;
    logic [IDW-1:0] id_q [LAT];
    logic [IDW-1:0] id_d [LAT];
    logic [23:0]    p_q  [LAT];
    logic [23:0]    p_d  [LAT];

    // Grant search results and selected operands
    logic           gnt_found;
    logic [IDW-1:0] gnt_idx;
    logic [IDW-1:0] scan_idx;
    logic [11:0]    a_sel;
    logic [11:0]    b_sel;
    logic [23:0]    prod;

    // Search upward from ptr (mod NREQ) for the first valid requester; no grant while stalled
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        scan_idx  = '0;
        if (!stall) begin
            for (int off = 0; off < NREQ; off++) begin
                // IDW-bit addition wraps modulo NREQ because NREQ is a power of two
                scan_idx = ptr_q + IDW'(off);
                if (!gnt_found && req_valid[scan_idx]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = scan_idx;
                end
            end
        end
    end

    // One-hot grant decode and operand selection for the winning requester
    always_comb begin
        req_ready = '0;
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
        a_sel = req_a[12*gnt_idx +: 12];
        b_sel = req_b[12*gnt_idx +: 12];
        prod  = {12'd0, a_sel} * {12'd0, b_sel};
    end

    // Next-state: advance pointer, counter and pipeline only on non-stall cycles
    always_comb begin
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        vld_d = vld_q;
        id_d  = id_q;
        p_d   = p_q;
        if (!stall) begin
            if (gnt_found) begin
                ptr_d = gnt_idx + 1'b1;
                cnt_d = cnt_q + 16'd1;
            end
            vld_d[0] = gnt_found;
            id_d[0]  = gnt_idx;
            p_d[0]   = prod;
            for (int s = 1; s < LAT; s++) begin
                vld_d[s] = vld_q[s-1];
                id_d[s]  = id_q[s-1];
                p_d[s]   = p_q[s-1];
            end
        end
    end

    // State registers; reset takes priority over stall and discards in-flight work
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
            vld_q <= '0;
            for (int s = 0; s < LAT; s++) begin
                id_q[s] <= '0;
                p_q[s]  <= '0;
            end
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            vld_q <= vld_d;
            for (int s = 0; s < LAT; s++) begin
                id_q[s] <= id_d[s];
                p_q[s]  <= p_d[s];
            end
        end
    end

    // The response stage keeps its valid bit through a stall so the result is
    // delivered after release; the visible pulse is suppressed while stalled.
    always_comb begin
        rsp_valid = vld_q[LAT-1] & ~stall;
        rsp_id    = id_q[LAT-1];
        rsp_p     = p_q[LAT-1];
        op_count  = cnt_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_intmul_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_intmul_arbiter
// Brief    : Directed self-checking bench for intmul_arbiter (NREQ=4, LAT=3)
// Revision : 1.0 - initial release
// ============================================================================
module tb_intmul_arbiter;

    localparam int NREQ = 4;
    localparam int LAT  = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NREQ-1:0]    req_valid;
    logic [12*NREQ-1:0] req_a;
    logic [12*NREQ-1:0] req_b;
    logic [NREQ-1:0]    req_ready;
    logic               stall;
    logic               rsp_valid;
    logic [1:0]         rsp_id;
    logic [23:0]        rsp_p;
    logic [15:0]        op_count;

    int checks = 0;
    int errors = 0;

    intmul_arbiter #(.NREQ(NREQ), .LAT(LAT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .stall     (stall),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_p     (rsp_p),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; land 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [11:0] a, input logic [11:0] b);
        req_a[12*i +: 12] = a;
        req_b[12*i +: 12] = b;
    endtask

    task automatic chk_rsp(input string tag, input logic v, input logic [1:0] id, input logic [23:0] p);
        chk({tag, "_valid"}, 32'(rsp_valid), 32'(v));
        if (v) begin
            chk({tag, "_id"}, 32'(rsp_id), 32'(id));
            chk({tag, "_p"},  32'(rsp_p),  32'(p));
        end
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;

        // ---------------- Reset state ----------------
        tick();
        tick();
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_id",    32'(rsp_id),    32'd0);
        chk("reset_rsp_p",     32'(rsp_p),     32'd0);
        chk("reset_op_count",  32'(op_count),  32'd0);
        reset = 1'b0;

        // ---------------- Basic product: requester 2 ----------------
        set_op(2, 12'd3328, 12'd3328);
        req_valid = 4'b0100;
        #1;
        chk("basic_ready", 32'(req_ready), 32'b0100);
        tick();
        req_valid = '0;
        chk("basic_count", 32'(op_count), 32'd1);
        chk_rsp("basic_k1", 1'b0, 2'd0, 24'd0);
        tick();
        chk_rsp("basic_k2", 1'b0, 2'd0, 24'd0);
        tick();
        chk_rsp("basic_k3", 1'b1, 2'd2, 24'hA90000);
        tick();
        chk_rsp("basic_k4", 1'b0, 2'd0, 24'd0);

        // ---------------- Extreme operands: requester 3 (ptr is 3) ----------------
        set_op(3, 12'd4095, 12'd4095);
        req_valid = 4'b1000;
        #1;
        chk("ext_ready", 32'(req_ready), 32'b1000);
        tick();
        req_valid = '0;
        tick();
        tick();
        chk_rsp("ext", 1'b1, 2'd3, 24'hFFE001);
        chk("ext_count", 32'(op_count), 32'd2);

        // ---------------- Round robin under full load (ptr is 0) ----------------
        for (int i = 0; i < NREQ; i++) set_op(i, 12'(i + 1), 12'd10);
        req_valid = 4'b1111;
        for (int c = 0; c < 8; c++) begin
            #1;
            chk($sformatf("rr_ready_%0d", c), 32'(req_ready), 32'(1 << (c % 4)));
            tick();
            if (c >= 2)
                chk_rsp($sformatf("rr_rsp_%0d", c - 2), 1'b1, 2'((c - 2) % 4), 24'(10 * ((c - 2) % 4 + 1)));
        end
        req_valid = '0;
        chk("rr_count", 32'(op_count), 32'd10);
        tick();
        chk_rsp("rr_rsp_6", 1'b1, 2'd2, 24'd30);
        tick();
        chk_rsp("rr_rsp_7", 1'b1, 2'd3, 24'd40);
        tick();
        chk_rsp("rr_idle", 1'b0, 2'd0, 24'd0);

        // ---------------- Pointer skip ----------------
        set_op(0, 12'd5, 12'd7);
        set_op(3, 12'd100, 12'd200);
        req_valid = 4'b0001;
        tick();                         // grant 0 -> ptr = 1
        req_valid = 4'b1001;
        #1;
        chk("skip_ready_a", 32'(req_ready), 32'b1000);
        tick();                         // grant 3 -> ptr = 0
        chk("skip_ready_b", 32'(req_ready), 32'b0001);
        tick();                         // grant 0 -> ptr = 1
        req_valid = '0;
        chk("skip_count", 32'(op_count), 32'd13);
        tick();
        tick();
        tick();

        // ---------------- Stall mid-flight (ptr is 1) ----------------
        set_op(1, 12'd11, 12'd13);
        set_op(2, 12'd17, 12'd19);
        set_op(3, 12'd23, 12'd29);
        req_valid = 4'b0010;
        tick();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1000;
        tick();
        stall     = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("stall1_ready", 32'(req_ready), 32'd0);
        chk("stall1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("stall2_ready", 32'(req_ready), 32'd0);
        chk("stall2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        stall     = 1'b0;
        req_valid = '0;
        #1;
        chk("stall_count", 32'(op_count), 32'd16);
        chk_rsp("stall_rsp_0", 1'b1, 2'd1, 24'd143);
        tick();
        chk_rsp("stall_rsp_1", 1'b1, 2'd2, 24'd323);
        tick();
        chk_rsp("stall_rsp_2", 1'b1, 2'd3, 24'd667);
        tick();
        chk_rsp("stall_after", 1'b0, 2'd0, 24'd0);

        // ---------------- Reset mid-operation (ptr is 0) ----------------
        set_op(0, 12'd2, 12'd3);
        set_op(1, 12'd4, 12'd5);
        req_valid = 4'b0001;
        tick();
        req_valid = 4'b0010;
        tick();                         // two ops in flight, ptr = 2
        req_valid = '0;
        reset     = 1'b1;
        stall     = 1'b1;               // reset must win over stall
        tick();
        reset = 1'b0;
        stall = 1'b0;
        #1;
        chk("rst_count", 32'(op_count), 32'd0);
        chk("rst_rsp_valid_0", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_id",      32'(rsp_id),    32'd0);
        chk("rst_rsp_p",       32'(rsp_p),     32'd0);
        tick();
        chk("rst_rsp_valid_1", 32'(rsp_valid), 32'd0);
        tick();
        chk("rst_rsp_valid_2", 32'(rsp_valid), 32'd0);
        req_valid = 4'b1111;
        #1;
        chk("rst_ptr_ready", 32'(req_ready), 32'b0001);

        // ---------------- Single requester every cycle, counter wrap ----------------
        set_op(0, 12'd1, 12'd1);
        req_valid = 4'b0001;
        #1;
        chk("single_ready", 32'(req_ready), 32'b0001);
        tick();
        chk("single_count", 32'(op_count), 32'd1);
        #1;
        chk("single_ready_again", 32'(req_ready), 32'b0001);
        for (int n = 0; n < 65533; n++) tick();
        chk("wrap_pre", 32'(op_count), 32'd65534);
        tick();
        chk("wrap_ffff", 32'(op_count), 32'd65535);
        tick();
        chk("wrap_zero", 32'(op_count), 32'd0);
        tick();
        chk("wrap_one", 32'(op_count), 32'd1);
        req_valid = '0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
